// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared constants for the DDRAM write/read arbiter.
// FSM encodings are plain logic constants so that checkers can bind to the
// exported state value without depending on an enum type.
package ddram_arb_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_READ_CMD  = 2'd2;
  localparam logic [1:0] ST_READ_WAIT = 2'd3;

  // Last-grant memory for round-robin
  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  // Write FIFO entry layout: {addr[28:0], be[7:0], data[63:0]}
  localparam int ENTRY_W = 101;

  // Every DDRAM command is a single-beat burst
  localparam logic [7:0] BURST_ONE = 8'd1;

endpackage

// File: rtl/ddram_arb_fifo.sv
// ddram_arb_fifo: synchronous FIFO for buffered pixel writes.
// Full/empty derive from the registered level, so a push arriving while the
// FIFO is full is dropped even if a pop happens in the same cycle.
module ddram_arb_fifo
  import ddram_arb_pkg::*;
#(
  parameter int W  = ENTRY_W,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [1<<AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ddram_wr_rd_arbiter.sv
// ddram_wr_rd_arbiter: shares one DDRAM Avalon port between a buffered
// fire-and-forget write stream and a single-outstanding read client.
// Optional feature macro: DDRAM_ARB_STATS_EN adds drop/peak-level statistics.
//
// Handshake semantics: a DDRAM command (WE or RD) is presented with its
// fields registered and held stable while DDRAM_BUSY=1; it is accepted on the
// first rising edge where DDRAM_BUSY=0. Read data returns later on
// DDRAM_DOUT_READY. wr_req has no backpressure; rd_req is honoured only while
// rd_busy=0 and rd_valid=0.
module ddram_wr_rd_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int FIFO_AW  = 4,
  parameter int HI_WATER = 12
) (
  input  logic               CLK_VIDEO,
  input  logic               RESET_N,
  input  logic               wr_req,
  input  logic [28:0]        wr_addr,
  input  logic [63:0]        wr_data,
  input  logic [7:0]         wr_be,
  output logic               wr_overflow,
  output logic [FIFO_AW:0]   wr_level,
  input  logic               rd_req,
  input  logic [28:0]        rd_addr,
  output logic               rd_busy,
  output logic [63:0]        rd_data,
  output logic               rd_valid,
  input  logic               DDRAM_BUSY,
  output logic [7:0]         DDRAM_BURSTCNT,
  output logic [28:0]        DDRAM_ADDR,
  output logic [63:0]        DDRAM_DIN,
  output logic [7:0]         DDRAM_BE,
  output logic               DDRAM_WE,
  output logic               DDRAM_RD,
  input  logic [63:0]        DDRAM_DOUT,
  input  logic               DDRAM_DOUT_READY,
`ifdef DDRAM_ARB_STATS_EN
  output logic [15:0]        stat_drops,
  output logic [FIFO_AW:0]   stat_max_level,
`endif
  output logic [1:0]         dbg_state
);

  localparam logic [FIFO_AW:0] HI_L = HI_WATER[FIFO_AW:0];

  logic [1:0]         state;
  logic               last_grant;
  logic               rd_pend;
  logic [28:0]        rd_addr_q;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               rd_accept;
  logic               wr_drop;

  assign dbg_state      = state;
  assign DDRAM_BURSTCNT = BURST_ONE;
  assign fifo_pop       = (state == ST_WRITE) && !DDRAM_BUSY;
  assign rd_accept      = rd_req && !rd_busy && !rd_valid;
  assign wr_drop        = wr_req && fifo_full;

  ddram_arb_fifo #(.W(ENTRY_W), .AW(FIFO_AW)) u_fifo (
    .clk   (CLK_VIDEO),
    .rst_n (RESET_N),
    .push  (wr_req),
    .din   ({wr_addr, wr_be, wr_data}),
    .pop   (fifo_pop),
    .dout  (head),
    .level (wr_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) wr_overflow <= 1'b0;
    else if (wr_drop) wr_overflow <= 1'b1;
  end

  // Arbitration FSM, read request capture and registered DDRAM command fields
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_READ;
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      DDRAM_WE   <= 1'b0;
      DDRAM_RD   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_accept) begin
        rd_addr_q <= rd_addr;
        rd_busy   <= 1'b1;
        rd_pend   <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          // High water forces a write; otherwise reads alternate with writes
          if (wr_level >= HI_L || (!fifo_empty &&
              !(rd_pend && last_grant == GRANT_WRITE))) begin
            state      <= ST_WRITE;
            DDRAM_WE   <= 1'b1;
            DDRAM_ADDR <= head[100:72];
            DDRAM_BE   <= head[71:64];
            DDRAM_DIN  <= head[63:0];
          end else if (rd_pend) begin
            state      <= ST_READ_CMD;
            DDRAM_RD   <= 1'b1;
            DDRAM_ADDR <= rd_addr_q;
          end
        end
        ST_WRITE: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE   <= 1'b0;
            last_grant <= GRANT_WRITE;
            state      <= ST_IDLE;
          end
        end
        ST_READ_CMD: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD   <= 1'b0;
            rd_pend    <= 1'b0;
            last_grant <= GRANT_READ;
            state      <= ST_READ_WAIT;
          end
        end
        default: begin
          if (DDRAM_DOUT_READY) begin
            rd_data  <= DDRAM_DOUT;
            rd_valid <= 1'b1;
            rd_busy  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DDRAM_ARB_STATS_EN
  // Saturating drop counter and peak FIFO occupancy
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_drops     <= '0;
      stat_max_level <= '0;
    end else begin
      if (wr_drop && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 1'b1;
      if (wr_level > stat_max_level) stat_max_level <= wr_level;
    end
  end
`endif

endmodule

// File: tb/tb_ddram_wr_rd_arbiter.sv
// tb_ddram_wr_rd_arbiter: scoreboard bench for the DDRAM write/read arbiter.
module tb_ddram_wr_rd_arbiter;

  logic        CLK_VIDEO = 1'b0;
  logic        RESET_N;
  logic        wr_req;
  logic [28:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        wr_overflow;
  logic [4:0]  wr_level;
  logic        rd_req;
  logic [28:0] rd_addr;
  logic        rd_busy;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic [1:0]  dbg_state;
`ifdef DDRAM_ARB_STATS_EN
  logic [15:0] stat_drops;
  logic [4:0]  stat_max_level;
`endif

  ddram_wr_rd_arbiter #(.FIFO_AW(4), .HI_WATER(12)) dut (
    .CLK_VIDEO        (CLK_VIDEO),
    .RESET_N          (RESET_N),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_be            (wr_be),
    .wr_overflow      (wr_overflow),
    .wr_level         (wr_level),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_busy          (rd_busy),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
`ifdef DDRAM_ARB_STATS_EN
    .stat_drops       (stat_drops),
    .stat_max_level   (stat_max_level),
`endif
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK_VIDEO = ~CLK_VIDEO;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard state ----------------
  logic [100:0] exp_wr_q[$];   // {addr, be, data} of writes expected on DDRAM
  logic [28:0]  exp_ra_q[$];   // read addresses expected on DDRAM
  logic [63:0]  exp_rd_q[$];   // read data expected on rd_data
  bit           grant_log[$];  // accepted commands: 1 = write, 0 = read
  int           we_cycles = 0;
  int           rv_cycles = 0;
  int           resp_wait = 0;
  logic [63:0]  resp_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor and memory responder, sampling on the falling edge
  always @(negedge CLK_VIDEO) begin
    DDRAM_DOUT_READY = 1'b0;
    if (resp_wait != 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = resp_data;
      end
    end
    if (DDRAM_WE || DDRAM_RD) check_eq("cmd_excl", DDRAM_WE & DDRAM_RD, 0);
    if (DDRAM_WE) begin
      we_cycles++;
      if (exp_wr_q.size() == 0) check_eq("we_unexpected", 1, 0);
      else begin
        check_eq("we_addr", DDRAM_ADDR, exp_wr_q[0][100:72]);
        check_eq("we_be",   DDRAM_BE,   exp_wr_q[0][71:64]);
        check_eq("we_din",  DDRAM_DIN,  exp_wr_q[0][63:0]);
        if (!DDRAM_BUSY) begin
          void'(exp_wr_q.pop_front());
          grant_log.push_back(1'b1);
        end
      end
    end
    if (DDRAM_RD) begin
      if (exp_ra_q.size() == 0) check_eq("rd_unexpected", 1, 0);
      else begin
        check_eq("rd_addr", DDRAM_ADDR, exp_ra_q[0]);
        if (!DDRAM_BUSY) begin
          void'(exp_ra_q.pop_front());
          grant_log.push_back(1'b0);
          resp_wait = 3;
        end
      end
    end
    if (rd_valid) begin
      rv_cycles++;
      if (exp_rd_q.size() == 0) check_eq("rv_unexpected", 1, 0);
      else check_eq("rd_data", rd_data, exp_rd_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic drive_write(input logic [28:0] a, input logic [7:0] be,
                             input logic [63:0] d, input bit keep);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    if (keep) exp_wr_q.push_back({a, be, d});
    tick();
    wr_req = 1'b0;
  endtask

  task automatic drive_read(input logic [28:0] a, input logic [63:0] d,
                            input bit keep);
    rd_req  = 1'b1;
    rd_addr = a;
    if (keep) begin
      exp_ra_q.push_back(a);
      exp_rd_q.push_back(d);
      resp_data = d;
    end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_ra_q.size() != 0 ||
            exp_rd_q.size() != 0 || dbg_state != 2'd0) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check_eq("drain_timeout", 1, 0);
    tick();
  endtask

  task automatic check_log(input string tag, input int base, input bit exp_seq[$]);
    check_eq({tag, "_len"}, grant_log.size() - base, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (base + i < grant_log.size())
        check_eq({tag, "_order"}, grant_log[base + i], exp_seq[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  base;
    int  snap;
    bit  seq[$];

    RESET_N = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_req = 1'b0; rd_addr = '0; DDRAM_BUSY = 1'b0;
    DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    repeat (3) @(posedge CLK_VIDEO);
    #1 RESET_N = 1'b1;
    tick();

    // 1: reset state
    check_eq("rst_we", DDRAM_WE, 0);
    check_eq("rst_rd", DDRAM_RD, 0);
    check_eq("rst_addr", DDRAM_ADDR, 0);
    check_eq("rst_din", DDRAM_DIN, 0);
    check_eq("rst_be", DDRAM_BE, 0);
    check_eq("rst_burst", DDRAM_BURSTCNT, 1);
    check_eq("rst_level", wr_level, 0);
    check_eq("rst_ovf", wr_overflow, 0);
    check_eq("rst_rdbusy", rd_busy, 0);
    check_eq("rst_rdvalid", rd_valid, 0);
    check_eq("rst_rddata", rd_data, 0);
    check_eq("rst_state", dbg_state, 0);
`ifdef DDRAM_ARB_STATS_EN
    check_eq("rst_drops", stat_drops, 0);
    check_eq("rst_maxlvl", stat_max_level, 0);
`endif

    // 2: single write, latency N+2
    drive_write(29'h1000, 8'h0F, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
    check_eq("t2_level_n1", wr_level, 1);
    check_eq("t2_we_n1", DDRAM_WE, 0);
    tick();
    check_eq("t2_we_n2", DDRAM_WE, 1);
    tick();
    check_eq("t2_we_after", DDRAM_WE, 0);
    check_eq("t2_level_end", wr_level, 0);
    check_eq("t2_sb_empty", exp_wr_q.size(), 0);

    // 3: BUSY held through five WE cycles, accepted on the sixth
    DDRAM_BUSY = 1'b1;
    snap = we_cycles;
    drive_write(29'h2000, 8'hF0, 64'h0123_4567_89AB_CDEF, 1'b1);
    repeat (5) tick();
    check_eq("t3_level_hold", wr_level, 1);
    tick();
    DDRAM_BUSY = 1'b0;
    tick();
    check_eq("t3_we_cycles", we_cycles - snap, 6);
    check_eq("t3_level_end", wr_level, 0);
    check_eq("t3_sb_empty", exp_wr_q.size(), 0);

    // 4: 17 back-to-back writes into a stalled port; the 17th is dropped
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 17; i++)
      drive_write(29'h3000 + 29'(i), 8'($urandom_range(0, 255)),
                  {$urandom, $urandom}, i < 16);
    check_eq("t4_level_full", wr_level, 16);
    check_eq("t4_overflow", wr_overflow, 1);
`ifdef DDRAM_ARB_STATS_EN
    check_eq("t4_drops", stat_drops, 1);
    check_eq("t4_maxlvl", stat_max_level, 16);
`endif
    DDRAM_BUSY = 1'b0;
    wait_drain();
    check_eq("t4_level_end", wr_level, 0);
    check_eq("t4_ovf_sticky", wr_overflow, 1);

    // 5: read pending with level 3 alternates write/read; busy rd_req ignored
    DDRAM_BUSY = 1'b1;
    base = grant_log.size();
    snap = rv_cycles;
    for (int i = 0; i < 3; i++)
      drive_write(29'h4000 + 29'(i), 8'hFF, {$urandom, $urandom}, 1'b1);
    drive_read(29'h50, 64'h0000_0000_DEAD_BEEF, 1'b1);
    check_eq("t5_rdbusy", rd_busy, 1);
    drive_read(29'h999, 64'h0, 1'b0);
    DDRAM_BUSY = 1'b0;
    wait_drain();
    seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    check_log("t5_grant", base, seq);
    check_eq("t5_rv_cycles", rv_cycles - snap, 1);
    check_eq("t5_rdbusy_end", rd_busy, 0);

    // 6: high water at 12 keeps writes ahead of a pending read
    DDRAM_BUSY = 1'b1;
    base = grant_log.size();
    for (int i = 0; i < 13; i++)
      drive_write(29'h5000 + 29'(i), 8'h3C, {$urandom, $urandom}, 1'b1);
    check_eq("t6_level", wr_level, 13);
    drive_read(29'h77, 64'h0123_4567_89AB_CDEF, 1'b1);
    DDRAM_BUSY = 1'b0;
    wait_drain();
    seq = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) seq.push_back(1'b1);
    check_log("t6_grant", base, seq);
    check_eq("t6_level_end", wr_level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
